// File: rtl/terrain_pkg.sv
// Shared types and default widths for the terrain generator and the terrain height store.
package terrain_pkg;
  typedef enum logic [1:0] {TG_IDLE, TG_SEED, TG_WALK, TG_DONE} tg_state_t;

  localparam int TG_SLOPE_MAX = 4;
  localparam int TG_HEIGHT_W  = 9;
  localparam int TG_ADDR_W    = 10;
endpackage

// File: rtl/tg_clamp.sv
// Saturating clamp from a signed sum onto an unsigned height range [MIN_V, MAX_V].
module tg_clamp #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 9,
  parameter int MIN_V = 64,
  parameter int MAX_V = 400
) (
  input  logic signed [IN_W-1:0] din,
  output logic [OUT_W-1:0]       dout
);
  localparam logic signed [IN_W-1:0] LO = IN_W'(MIN_V);
  localparam logic signed [IN_W-1:0] HI = IN_W'(MAX_V);

  function automatic logic [OUT_W-1:0] sat_range(input logic signed [IN_W-1:0] v);
    if (v < LO) return OUT_W'(MIN_V);
    if (v > HI) return OUT_W'(MAX_V);
    return v[OUT_W-1:0];
  endfunction

  assign dout = sat_range(din);
endmodule

// File: rtl/terrain_gen.sv
// Terrain height generator: clamped random walk over NUM_COLS columns, one registered write per column.
// Build option TERRAIN_SMOOTH_EN writes the 2-tap average of consecutive walk heights instead of the raw walk.
module terrain_gen
  import terrain_pkg::*;
#(
  parameter int NUM_COLS = 640,
  parameter int ADDR_W   = TG_ADDR_W,
  parameter int HEIGHT_W = TG_HEIGHT_W,
  parameter int MIN_H    = 64,
  parameter int MAX_H    = 400,
  parameter int BASE_H   = 160
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  input  logic [9:0]          rng,
  input  logic                wr_ready,
  output logic                we,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [HEIGHT_W-1:0] terrain_height,
  output logic                busy,
  output logic                done
);
  localparam int SW = HEIGHT_W + 2;
  localparam logic [ADDR_W-1:0]   LAST_COL    = ADDR_W'(NUM_COLS - 1);
  localparam logic signed [SW-1:0] MIN_S      = SW'(MIN_H);
  localparam logic signed [SW-1:0] MAX_S      = SW'(MAX_H);
  localparam logic signed [SW-1:0] SLOPE_LIM  = SW'(TG_SLOPE_MAX);
  localparam logic signed [3:0]    SLOPE_HI   = 4'(TG_SLOPE_MAX);
  localparam logic signed [3:0]    SLOPE_LO   = 4'(-TG_SLOPE_MAX);

  tg_state_t             state, state_n;
  logic [ADDR_W-1:0]     col, col_n;
  logic signed [3:0]     slope, slope_n, slope_c;
  logic [HEIGHT_W-1:0]   h, h_n, seed_h, walk_h, out_h;
  logic signed [SW-1:0]  seed_sum, step_d, walk_sum;
  logic                  walk_clamped;
  logic                  accept;
  logic                  unused_rng;

  function automatic logic signed [3:0] sat_slope(input logic signed [SW-1:0] v);
    if (v > SLOPE_LIM)  return SLOPE_HI;
    if (v < -SLOPE_LIM) return SLOPE_LO;
    return v[3:0];
  endfunction

  assign unused_rng = &{1'b0, rng[9:7]};
  assign accept     = (state == TG_WALK) && wr_ready;

  // Step is rng[1:0] as two's complement; 3'b110 is pulled from -2 to -1 to offset the downward bias.
  always_comb begin
    step_d = SW'($signed(rng[1:0]));
    if (rng[2:0] == 3'b110) step_d = SW'(-1);
    slope_c  = sat_slope(SW'(slope) + step_d);
    walk_sum = $signed({2'b00, h}) + SW'(slope_c);
  end

  assign seed_sum     = SW'(BASE_H) + $signed(SW'(rng[6:0]));
  assign walk_clamped = (walk_sum < MIN_S) || (walk_sum > MAX_S);

  tg_clamp #(.IN_W(SW), .OUT_W(HEIGHT_W), .MIN_V(MIN_H), .MAX_V(MAX_H)) u_seed_clamp (
    .din  (seed_sum),
    .dout (seed_h)
  );

  tg_clamp #(.IN_W(SW), .OUT_W(HEIGHT_W), .MIN_V(MIN_H), .MAX_V(MAX_H)) u_walk_clamp (
    .din  (walk_sum),
    .dout (walk_h)
  );

  always_comb begin
    state_n = state;
    col_n   = col;
    slope_n = slope;
    h_n     = h;
    case (state)
      TG_IDLE: if (start) state_n = TG_SEED;
      TG_SEED: begin
        h_n     = seed_h;
        col_n   = '0;
        slope_n = '0;
        state_n = TG_WALK;
      end
      TG_WALK: if (accept) begin
        col_n   = col + 1'b1;
        h_n     = walk_h;
        slope_n = walk_clamped ? 4'sd0 : slope_c;
        if (col == LAST_COL) state_n = TG_DONE;
      end
      TG_DONE: state_n = TG_IDLE;
      default: state_n = TG_IDLE;
    endcase
  end

`ifdef TERRAIN_SMOOTH_EN
  logic [HEIGHT_W-1:0] h_prev, h_prev_n;

  function automatic logic [HEIGHT_W-1:0] avg2(input logic [HEIGHT_W-1:0] a,
                                               input logic [HEIGHT_W-1:0] b);
    logic [HEIGHT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[HEIGHT_W:1];
  endfunction

  assign h_prev_n = accept ? h : h_prev;
  assign out_h    = (col_n == '0) ? h_n : avg2(h_n, h_prev_n);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) h_prev <= '0;
    else          h_prev <= h_prev_n;
  end
`else
  assign out_h = h_n;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= TG_IDLE;
      col   <= '0;
      slope <= '0;
      h     <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      slope <= slope_n;
      h     <= h_n;
    end
  end

  // Outputs are registered from next-state values so a write appears the cycle after it is decided.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we             <= 1'b0;
      write_addr     <= '0;
      terrain_height <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      we         <= (state_n == TG_WALK);
      busy       <= (state_n == TG_SEED) || (state_n == TG_WALK);
      done       <= (state_n == TG_DONE);
      write_addr <= (state_n == TG_WALK) ? col_n : '0;
      if (state_n == TG_WALK) terrain_height <= out_h;
    end
  end
endmodule

// File: tb/tb_terrain_gen.sv
// Bench for terrain_gen: directed seed/slope vectors plus full sweeps against a behavioural walk model.
module tb_terrain_gen;
  localparam int NUM_COLS = 640;
  localparam int ADDR_W   = 10;
  localparam int HEIGHT_W = 9;
  localparam int MIN_H    = 64;
  localparam int MAX_H    = 400;
  localparam int BASE_H   = 160;
  localparam int HI_COLS  = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, start_hi;
  logic [9:0]          rng;
  logic                wr_ready;
  logic                we, busy, done;
  logic [ADDR_W-1:0]   write_addr;
  logic [HEIGHT_W-1:0] terrain_height;
  logic                hi_we, hi_busy, hi_done;
  logic [ADDR_W-1:0]   hi_addr;
  logic [HEIGHT_W-1:0] hi_h;

  int n_vec  = 0;
  int n_miss = 0;
  int rng_tab[0:1023];

  int hi_rng[HI_COLS] = '{10'h001, 10'h003, 10'h006, 10'h002, 10'h002, 10'h000};
`ifdef TERRAIN_SMOOTH_EN
  int hi_exp[HI_COLS] = '{400, 400, 399, 398, 395, 391};
`else
  int hi_exp[HI_COLS] = '{400, 400, 399, 397, 393, 389};
`endif

  always #5 clk = ~clk;

  terrain_gen u_dut (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .start          (start),
    .rng            (rng),
    .wr_ready       (wr_ready),
    .we             (we),
    .write_addr     (write_addr),
    .terrain_height (terrain_height),
    .busy           (busy),
    .done           (done)
  );

  terrain_gen #(.NUM_COLS(HI_COLS), .BASE_H(390)) u_dut_hi (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .start          (start_hi),
    .rng            (rng),
    .wr_ready       (wr_ready),
    .we             (hi_we),
    .write_addr     (hi_addr),
    .terrain_height (hi_h),
    .busy           (hi_busy),
    .done           (hi_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_h(input int v);
    if (v < MIN_H) return MIN_H;
    if (v > MAX_H) return MAX_H;
    return v;
  endfunction

  task automatic model_step(input int r, inout int h, inout int s);
    int d, t;
    d = r & 3;
    if (d >= 2) d = d - 4;
    if ((r & 7) == 6) d = -1;
    s = s + d;
    if (s > 4)  s = 4;
    if (s < -4) s = -4;
    t = h + s;
    if (t < MIN_H || t > MAX_H) begin
      h = clamp_h(t);
      s = 0;
    end else begin
      h = t;
    end
  endtask

  // One generation on u_dut: toggle stalls every other cycle, poke_col pulses start mid-sweep,
  // rst_col asserts reset when that column is on the bus (-1 disables each).
  task automatic run_gen(input bit toggle, input int poke_col, input int rst_col);
    int k, m_h, m_s, m_prev, n_wr, n_done, cyc, exp_h, last_h, post, dh;
    bit poked;
    k = 0; m_h = 0; m_s = 0; m_prev = 0; n_wr = 0; n_done = 0;
    cyc = 0; post = 0; last_h = 0; poked = 0;
    @(negedge clk);
    start = 1'b1; rng = 10'($urandom); wr_ready = 1'b1;
    while (post < 3) begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      rng      = 10'($urandom);
      wr_ready = 1'b1;
      if (cyc > 4 * NUM_COLS) begin
        chk("timeout", cyc, 0);
        return;
      end
      if (busy && !we) begin
        chk("seed_cycle", cyc, 1);
        rng = 10'(rng_tab[k]);
        k++;
        m_h = clamp_h(BASE_H + int'(rng[6:0]));
        m_s = 0;
      end else if (we) begin
        if (rst_col >= 0 && n_wr == rst_col) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_we", we, 0);
          chk("rst_busy", busy, 0);
          chk("rst_addr", write_addr, 0);
          chk("rst_height", terrain_height, 0);
          chk("rst_done", done, 0);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
`ifdef TERRAIN_SMOOTH_EN
        exp_h = (n_wr == 0) ? m_h : (m_h + m_prev) / 2;
`else
        exp_h = m_h;
`endif
        chk("addr", write_addr, n_wr);
        chk("height", terrain_height, exp_h);
`ifndef TERRAIN_SMOOTH_EN
        chk("range", (terrain_height >= MIN_H) && (terrain_height <= MAX_H), 1);
        if (n_wr > 0) begin
          dh = int'(terrain_height) - last_h;
          chk("step", (dh <= 4) && (dh >= -4), 1);
        end
`endif
        if (!poked && n_wr == poke_col) begin
          start = 1'b1;
          poked = 1'b1;
        end
        wr_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
        if (wr_ready) begin
          rng = 10'(rng_tab[k]);
          k++;
          last_h = int'(terrain_height);
          m_prev = m_h;
          model_step(int'(rng), m_h, m_s);
          n_wr++;
        end
      end else if (done) begin
        n_done++;
        chk("done_busy", busy, 0);
        chk("done_writes", n_wr, NUM_COLS);
        if (!toggle) chk("done_cycle", cyc, NUM_COLS + 2);
      end else if (n_done > 0) begin
        post++;
      end
    end
    chk("done_count", n_done, 1);
    chk("total_writes", n_wr, NUM_COLS);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_hi = 1'b0; rng = '0; wr_ready = 1'b1;
    for (int i = 0; i < 1024; i++) rng_tab[i] = int'($urandom_range(0, 1023));
    repeat (3) @(negedge clk);
    chk("rst_val_we", we, 0);
    chk("rst_val_addr", write_addr, 0);
    chk("rst_val_height", terrain_height, 0);
    chk("rst_val_busy", busy, 0);
    chk("rst_val_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_we", we, 0);
    chk("idle_busy", busy, 0);

    // Seed clamp at MAX_H and hand-computed slope steps on the high-base instance.
    start_hi = 1'b1;
    @(negedge clk);
    start_hi = 1'b0;
    chk("hi_seed_busy", hi_busy, 1);
    chk("hi_seed_we", hi_we, 0);
    rng = 10'h07F;
    for (int i = 0; i < HI_COLS; i++) begin
      @(negedge clk);
      chk("hi_we", hi_we, 1);
      chk("hi_addr", hi_addr, i);
      chk("hi_height", hi_h, hi_exp[i]);
      rng = 10'(hi_rng[i]);
    end
    @(negedge clk);
    chk("hi_done", hi_done, 1);
    chk("hi_done_we", hi_we, 0);
    chk("hi_done_busy", hi_busy, 0);
    @(negedge clk);
    chk("hi_done_pulse", hi_done, 0);
    chk("hi_hold_height", hi_h, hi_exp[HI_COLS-1]);

    run_gen(1'b0, 100, -1);
    run_gen(1'b1, -1, -1);
    run_gen(1'b0, -1, 300);
    run_gen(1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
